// File: rtl/cache_write_buffer.sv
// cache_write_buffer: circular FIFO of pending word writes between the
// direct-mapped cache and main memory. Drains the head entry with a
// request/ack handshake, coalesces repeat stores to non-head entries, and
// serves associative read lookups so the cache can bypass memory.
module cache_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_buffer,
  input  logic              read_buffer,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wData,
  output logic              full,
  output logic              empty,
  output logic              buffer_hit,
  output logic [DATA_W-1:0] data_read_from_buffer,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WA_W  = ADDR_W - 2;

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;
  logic [PTR_W-1:0]  look_idx;
  logic              do_pop;
  logic              do_append;
  logic [WA_W-1:0]   word_addr;

  assign word_addr = addr[ADDR_W-1:2];

  // Status and drain outputs, all derived from registered state only
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    mem_write = !empty;
    mem_addr  = empty ? '0 : addr_q[head_q];
    mem_data  = empty ? '0 : data_q[head_q];
    overflow  = overflow_q;
  end

  // Coalesce target: a valid entry other than the head with the same word address
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (PTR_W'(i) != head_q) && (addr_q[i][ADDR_W-1:2] == word_addr)) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  // Lookup walks oldest to youngest so the last match (youngest) wins
  always_comb begin
    buffer_hit            = 1'b0;
    data_read_from_buffer = '0;
    look_idx              = '0;
    if (read_buffer && !write_buffer) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        look_idx = PTR_W'(head_q + PTR_W'(k));
        if (valid_q[look_idx] && (addr_q[look_idx][ADDR_W-1:2] == word_addr)) begin
          buffer_hit            = 1'b1;
          data_read_from_buffer = data_q[look_idx];
        end
      end
    end
  end

  // Next-state: pop at head, coalesce or append at tail, sticky overflow
  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    do_pop    = mem_ack && !empty;
    do_append = write_buffer && !coal_hit && !full;

    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = PTR_W'(head_q + PTR_W'(1));
    end

    if (write_buffer && coal_hit) begin
      data_d[coal_idx] = wData;
    end else if (do_append) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = addr;
      data_d[tail_q]  = wData;
      tail_d          = PTR_W'(tail_q + PTR_W'(1));
    end else if (write_buffer) begin
      overflow_d = 1'b1;
    end

    // full is judged on the pre-edge count, so a same-cycle pop never admits a push
    if (do_append && !do_pop) begin
      count_d = CNT_W'(count_q + CNT_W'(1));
    end else if (do_pop && !do_append) begin
      count_d = CNT_W'(count_q - CNT_W'(1));
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed self-checking bench for cache_write_buffer.
module tb_cache_write_buffer;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              write_buffer;
  logic              read_buffer;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wData;
  logic              full;
  logic              empty;
  logic              buffer_hit;
  logic [DATA_W-1:0] data_read_from_buffer;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;
  logic              overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  cache_write_buffer #(.DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .write_buffer          (write_buffer),
    .read_buffer           (read_buffer),
    .addr                  (addr),
    .wData                 (wData),
    .full                  (full),
    .empty                 (empty),
    .buffer_hit            (buffer_hit),
    .data_read_from_buffer (data_read_from_buffer),
    .mem_write             (mem_write),
    .mem_addr              (mem_addr),
    .mem_data              (mem_data),
    .mem_ack               (mem_ack),
    .overflow              (overflow)
  );

  always #5 clock = ~clock;

  // Compare one observed value with its expected value
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    write_buffer = 1'b1;
    addr         = a;
    wData        = d;
    step();
    write_buffer = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [ADDR_W-1:0] a,
                        input logic exp_hit, input logic [DATA_W-1:0] exp_data);
    read_buffer = 1'b1;
    addr        = a;
    #1;
    check_eq({tag, "_hit"}, 64'(buffer_hit), 64'(exp_hit));
    check_eq({tag, "_data"}, 64'(data_read_from_buffer), 64'(exp_data));
    read_buffer = 1'b0;
    step();
  endtask

  task automatic drain(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    #1;
    check_eq({tag, "_mwr"}, 64'(mem_write), 64'd1);
    check_eq({tag, "_maddr"}, 64'(mem_addr), 64'(a));
    check_eq({tag, "_mdata"}, 64'(mem_data), 64'(d));
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    write_buffer = 1'b0;
    read_buffer  = 1'b0;
    addr         = '0;
    wData        = '0;
    mem_ack      = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset then idle
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_mwr", 64'(mem_write), 64'd0);
    check_eq("rst_maddr", 64'(mem_addr), 64'd0);
    check_eq("rst_mdata", 64'(mem_data), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    lookup("rst_look", 32'h0000_0000, 1'b0, 32'h0);

    // Two pushes, held head, byte-offset lookup, in-order drain
    push(32'h040, 32'hAAAA_0001);
    check_eq("p1_mwr_next", 64'(mem_write), 64'd1);
    check_eq("p1_maddr_next", 64'(mem_addr), 64'h040);
    push(32'h044, 32'hAAAA_0002);
    step();
    check_eq("hold_maddr", 64'(mem_addr), 64'h040);
    check_eq("hold_mdata", 64'(mem_data), 64'hAAAA_0001);
    lookup("look046", 32'h046, 1'b1, 32'hAAAA_0002);
    lookup("look040", 32'h040, 1'b1, 32'hAAAA_0001);
    lookup("look048", 32'h048, 1'b0, 32'h0);
    read_buffer  = 1'b1;
    write_buffer = 1'b1;
    addr         = 32'h040;
    #1;
    check_eq("rw_push_wins", 64'(buffer_hit), 64'd0);
    read_buffer  = 1'b0;
    write_buffer = 1'b0;
    step();
    drain("d040", 32'h040, 32'hAAAA_0001);
    drain("d044", 32'h044, 32'hAAAA_0002);
    check_eq("drained_empty", 64'(empty), 64'd1);
    check_eq("drained_mwr", 64'(mem_write), 64'd0);

    // mem_ack while empty is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("ack_empty_empty", 64'(empty), 64'd1);
    check_eq("ack_empty_full", 64'(full), 64'd0);

    // Fill, push-while-full with same-cycle pop is dropped, then wrap
    push(32'h100, 32'hB0);
    push(32'h104, 32'hB1);
    push(32'h108, 32'hB2);
    push(32'h10C, 32'hB3);
    check_eq("fill_full", 64'(full), 64'd1);
    write_buffer = 1'b1;
    addr         = 32'h200;
    wData        = 32'hDEAD;
    mem_ack      = 1'b1;
    #1;
    check_eq("drop_maddr_pre", 64'(mem_addr), 64'h100);
    step();
    write_buffer = 1'b0;
    mem_ack      = 1'b0;
    check_eq("drop_ovf", 64'(overflow), 64'd1);
    check_eq("drop_full", 64'(full), 64'd0);
    check_eq("drop_head", 64'(mem_addr), 64'h104);
    lookup("drop_look200", 32'h200, 1'b0, 32'h0);
    push(32'h300, 32'hC0);
    check_eq("wrap_full", 64'(full), 64'd1);
    drain("w104", 32'h104, 32'hB1);
    drain("w108", 32'h108, 32'hB2);
    drain("w10C", 32'h10C, 32'hB3);
    drain("w300", 32'h300, 32'hC0);
    check_eq("wrap_empty", 64'(empty), 64'd1);
    check_eq("ovf_sticky", 64'(overflow), 64'd1);

    // Coalescing into non-head, head match appended
    do_reset();
    check_eq("rst2_ovf", 64'(overflow), 64'd0);
    push(32'h080, 32'h1);
    push(32'h084, 32'h2);
    push(32'h084, 32'h3);
    lookup("coal084", 32'h084, 1'b1, 32'h3);
    push(32'h080, 32'h4);
    check_eq("coal_notfull", 64'(full), 64'd0);
    lookup("young080", 32'h080, 1'b1, 32'h4);
    push(32'h0F0, 32'h5);
    check_eq("coal_cnt4_full", 64'(full), 64'd1);
    drain("c080a", 32'h080, 32'h1);
    drain("c084", 32'h084, 32'h3);
    drain("c080b", 32'h080, 32'h4);
    drain("c0F0", 32'h0F0, 32'h5);
    check_eq("coal_empty", 64'(empty), 64'd1);

    // Push and pop in the same cycle at count 2
    push(32'h0C0, 32'h10);
    push(32'h0C4, 32'h11);
    write_buffer = 1'b1;
    addr         = 32'h0C8;
    wData        = 32'h12;
    mem_ack      = 1'b1;
    step();
    write_buffer = 1'b0;
    mem_ack      = 1'b0;
    check_eq("pp_head", 64'(mem_addr), 64'h0C4);
    check_eq("pp_full", 64'(full), 64'd0);
    // Entry popped at this edge still hits during the pop cycle
    read_buffer = 1'b1;
    addr        = 32'h0C4;
    mem_ack     = 1'b1;
    #1;
    check_eq("popcyc_hit", 64'(buffer_hit), 64'd1);
    check_eq("popcyc_data", 64'(data_read_from_buffer), 64'h11);
    step();
    read_buffer = 1'b0;
    mem_ack     = 1'b0;
    lookup("popped_miss", 32'h0C4, 1'b0, 32'h0);
    drain("pp0C8", 32'h0C8, 32'h12);
    check_eq("pp_empty", 64'(empty), 64'd1);

    // Reset mid-drain discards entries
    push(32'h400, 32'h20);
    push(32'h404, 32'h21);
    push(32'h408, 32'h22);
    check_eq("pre_rst_mwr", 64'(mem_write), 64'd1);
    do_reset();
    check_eq("mid_rst_empty", 64'(empty), 64'd1);
    check_eq("mid_rst_mwr", 64'(mem_write), 64'd0);
    lookup("mid_rst_look", 32'h400, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
